// File: rtl/btb_update_scheduler_pkg.sv
// Shared sizes and state encoding for the BTB update scheduler.
// Optional statistics outputs are enabled by defining BTB_UPD_STATS_EN.
package btb_update_scheduler_pkg;

   localparam int unsigned WORD_SIZE = 16;
   localparam int unsigned IDX_SIZE  = 8;
   localparam int unsigned TAG_SIZE  = WORD_SIZE - IDX_SIZE;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   // Queue entry layout: {pc, target, taken, mispredict}
   function automatic int unsigned entry_bits(input int unsigned word_bits);
      return 2 * word_bits + 2;
   endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// DEPTH-entry update queue with two ordered push ports (push0 is older) and one pop.
// Exposes the occupancy count and a view of the head entry.
module btb_upd_fifo
   import btb_update_scheduler_pkg::*;
#(
   parameter int unsigned EBITS = 34,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push0_i,
   input  logic [EBITS-1:0]           entry0_i,
   input  logic                       push1_i,
   input  logic [EBITS-1:0]           entry1_i,
   input  logic                       pop_i,
   output logic [EBITS-1:0]           head_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [EBITS-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    wr_ptr1;

   // A lone push1 lands at wr_ptr; behind push0 it takes the following slot.
   assign wr_ptr1 = wr_ptr_q + PW'(push0_i);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
      rd_ptr_d = rd_ptr_q + PW'(pop_i);
      count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push0_i) mem_q[wr_ptr_q] <= entry0_i;
      if (push1_i) mem_q[wr_ptr1]  <= entry1_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/btb_update_scheduler.sv
// Single owner of the predictor write port: invalidate sweep after reset, then
// queued EX/ID updates issued oldest first. BTB_UPD_STATS_EN adds update counters.
module btb_update_scheduler
   import btb_update_scheduler_pkg::*;
#(
   parameter int unsigned WORD_BITS = WORD_SIZE,
   parameter int unsigned IDX_BITS  = IDX_SIZE,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ex_valid,
   input  logic [WORD_BITS-1:0]          ex_pc,
   input  logic [WORD_BITS-1:0]          ex_target,
   input  logic                          ex_taken,
   input  logic                          ex_mispredict,
   input  logic                          id_valid,
   input  logic [WORD_BITS-1:0]          id_pc,
   input  logic [WORD_BITS-1:0]          id_target,
   input  logic                          id_mispredict,
   output logic                          req_stall,
   output logic                          upd_valid,
   input  logic                          upd_ready,
   output logic [IDX_BITS-1:0]           upd_idx,
   output logic [WORD_BITS-IDX_BITS-1:0] upd_tag,
   output logic [WORD_BITS-1:0]          upd_target,
   output logic                          upd_taken,
   output logic                          upd_mispredict,
   output logic                          upd_clear,
`ifdef BTB_UPD_STATS_EN
   output logic [15:0]                   stat_updates,
   output logic [15:0]                   stat_mispredicts,
`endif
   output logic                          init_done
);

   localparam int unsigned EW = entry_bits(WORD_BITS);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_e               state_q, state_d;
   logic [IDX_BITS-1:0]  clear_ptr_q, clear_ptr_d;
   logic [EW-1:0]        ex_entry, id_entry, head;
   logic [CW-1:0]        count;
   logic                 push_ex, push_id, pop;
   logic [WORD_BITS-1:0] head_pc, head_tgt;
   logic                 head_tk, head_mp;

   assign ex_entry = {ex_pc, ex_target, ex_taken, ex_mispredict};
   assign id_entry = {id_pc, id_target, 1'b1, id_mispredict};
   assign head_pc  = head[EW-1 -: WORD_BITS];
   assign head_tgt = head[WORD_BITS+1 -: WORD_BITS];
   assign head_tk  = head[1];
   assign head_mp  = head[0];

   btb_upd_fifo #(
      .EBITS (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push0_i  (push_ex),
      .entry0_i (ex_entry),
      .push1_i  (push_id),
      .entry1_i (id_entry),
      .pop_i    (pop),
      .head_o   (head),
      .count_o  (count)
   );

   // While reset is held every output shows its idle value, even in the first
   // reset cycle when the state register still holds RUN.
   always_comb begin
      state_d        = state_q;
      clear_ptr_d    = clear_ptr_q;
      req_stall      = 1'b1;
      upd_valid      = 1'b0;
      upd_clear      = 1'b0;
      upd_idx        = '0;
      upd_tag        = '0;
      upd_target     = '0;
      upd_taken      = 1'b0;
      upd_mispredict = 1'b0;
      init_done      = 1'b0;
      push_ex        = 1'b0;
      push_id        = 1'b0;
      pop            = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_CLEAR: begin
               upd_valid  = 1'b1;
               upd_clear  = 1'b1;
               upd_idx    = clear_ptr_q;
               upd_tag    = '1;
               upd_target = '1;
               if (upd_ready) begin
                  if (clear_ptr_q == '1) state_d = ST_RUN;
                  else                   clear_ptr_d = clear_ptr_q + 1'b1;
               end
            end
            ST_RUN: begin
               init_done      = 1'b1;
               req_stall      = (count > CW'(DEPTH - 2));
               upd_valid      = (count != '0);
               upd_idx        = head_pc[IDX_BITS-1:0];
               upd_tag        = head_pc[WORD_BITS-1:IDX_BITS];
               upd_target     = head_tgt;
               upd_taken      = head_tk;
               upd_mispredict = head_mp;
               push_ex        = ex_valid & ~req_stall;
               push_id        = id_valid & ~req_stall;
               pop            = upd_valid & upd_ready;
            end
            default: state_d = ST_CLEAR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_CLEAR;
         clear_ptr_q <= '0;
      end else begin
         state_q     <= state_d;
         clear_ptr_q <= clear_ptr_d;
      end
   end

`ifdef BTB_UPD_STATS_EN
   logic [15:0] stat_upd_q, stat_mis_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_upd_q <= '0;
         stat_mis_q <= '0;
      end else if (pop) begin
         if (stat_upd_q != '1)                  stat_upd_q <= stat_upd_q + 16'd1;
         if (head_mp && (stat_mis_q != '1))     stat_mis_q <= stat_mis_q + 16'd1;
      end
   end

   assign stat_updates     = stat_upd_q;
   assign stat_mispredicts = stat_mis_q;
`endif

endmodule
